// File: rtl/prefetch_line_buffer.sv
// prefetch_line_buffer: single-line read buffer that demand-fetches misses and
// prefetches the next sequential line after every upstream response.
module prefetch_line_buffer #(
   parameter int LINE_BYTES = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             mem_addr,
   input  logic                    mem_read,
   output logic [LINE_BYTES*8-1:0] mem_rdata,
   output logic                    mem_resp,
   output logic [31:0]             pmem_addr,
   output logic                    pmem_read,
   input  logic [LINE_BYTES*8-1:0] pmem_rdata,
   input  logic                    pmem_resp,
   output logic [31:0]             hit_count,
   output logic [31:0]             miss_count
);
   localparam int OW = $clog2(LINE_BYTES);
   localparam int TW = 32 - OW;
   localparam int DW = LINE_BYTES * 8;

   typedef enum logic [2:0] {IDLE, HIT_RESP, DEMAND, DEMAND_RESP, PREFETCH} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   buf_data_q, buf_data_d;
   logic [TW-1:0]   buf_tag_q, buf_tag_d;
   logic            buf_valid_q, buf_valid_d;
   logic [TW-1:0]   req_line_q, req_line_d;
   logic [TW-1:0]   pf_line_q, pf_line_d;
   logic [31:0]     hit_q, hit_d;
   logic [31:0]     miss_q, miss_d;
   logic            unused_ofs;

   assign unused_ofs = ^mem_addr[OW-1:0];

   always_comb begin
      state_d     = state_q;
      buf_data_d  = buf_data_q;
      buf_tag_d   = buf_tag_q;
      buf_valid_d = buf_valid_q;
      req_line_d  = req_line_q;
      pf_line_d   = pf_line_q;
      hit_d       = hit_q;
      miss_d      = miss_q;
      case (state_q)
         IDLE: if (mem_read) begin
            if (buf_valid_q && mem_addr[31:OW] == buf_tag_q) begin
               state_d = HIT_RESP;
               hit_d   = hit_q + 32'd1;
            end else begin
               state_d    = DEMAND;
               req_line_d = mem_addr[31:OW];
               miss_d     = miss_q + 32'd1;
            end
         end
         HIT_RESP, DEMAND_RESP: begin
            // tag arithmetic wraps naturally at the top of the address space
            pf_line_d = buf_tag_q + TW'(1);
            state_d   = PREFETCH;
         end
         DEMAND: if (pmem_resp) begin
            buf_data_d  = pmem_rdata;
            buf_tag_d   = req_line_q;
            buf_valid_d = 1'b1;
            state_d     = DEMAND_RESP;
         end
         PREFETCH: if (pmem_resp) begin
            buf_data_d  = pmem_rdata;
            buf_tag_d   = pf_line_q;
            buf_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         buf_data_q  <= '0;
         buf_tag_q   <= '0;
         buf_valid_q <= 1'b0;
         req_line_q  <= '0;
         pf_line_q   <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
      end else begin
         state_q     <= state_d;
         buf_data_q  <= buf_data_d;
         buf_tag_q   <= buf_tag_d;
         buf_valid_q <= buf_valid_d;
         req_line_q  <= req_line_d;
         pf_line_q   <= pf_line_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
      end
   end

   assign mem_rdata  = buf_data_q;
   assign mem_resp   = (state_q == HIT_RESP) || (state_q == DEMAND_RESP);
   assign pmem_read  = (state_q == DEMAND) || (state_q == PREFETCH);
   assign pmem_addr  = (state_q == DEMAND)   ? {req_line_q, {OW{1'b0}}} :
                       (state_q == PREFETCH) ? {pf_line_q, {OW{1'b0}}}  : 32'd0;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;
endmodule
